// File: rtl/comparator_arbiter_if.sv
// Requester/comparator bundle for comparator_arbiter.
// slave = arbiter side, master = requester/comparator side.
interface comparator_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 18
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] operand_a;
  logic [NUM_REQ*WIDTH-1:0] operand_b;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       done;
  logic                     result_zero;
  logic                     result_carry;
  logic                     busy;
  logic [WIDTH-1:0]         cmp_number1;
  logic [WIDTH-1:0]         cmp_number2;
  logic                     cmp_zero_flag;
  logic                     cmp_carry_flag;

  modport slave (
    input  req, operand_a, operand_b,
    input  cmp_zero_flag, cmp_carry_flag,
    output grant, done, result_zero, result_carry,
    output busy, cmp_number1, cmp_number2
  );

  modport master (
    output req, operand_a, operand_b,
    output cmp_zero_flag, cmp_carry_flag,
    input  grant, done, result_zero, result_carry,
    input  busy, cmp_number1, cmp_number2
  );
endinterface

// File: rtl/comparator_arbiter.sv
// Shares one external comparator among NUM_REQ requesters.
// Define CMP_ARB_ROUND_ROBIN_EN for round-robin, else fixed priority.
module comparator_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 18
) (
  input  logic               clk,
  input  logic               reset,
  comparator_arbiter_if.slave cmp_if
);
  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [NUM_REQ-1:0]  r_grant;
  logic [NUM_REQ-1:0]  r_done;
  logic [NUM_REQ-1:0]  w_win;
  logic [IDXW-1:0]     w_idx;
  logic                w_any;
  logic [WIDTH-1:0]    r_num1;
  logic [WIDTH-1:0]    r_num2;
  logic                r_zero;
  logic                r_carry;

`ifdef CMP_ARB_ROUND_ROBIN_EN
  logic [IDXW-1:0]     r_ptr;
  logic [IDXW-1:0]     r_idx;

  // search starts at the pointer and wraps
  always_comb begin
    int j;
    j     = 0;
    w_any = 1'b0;
    w_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(r_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!w_any && cmp_if.req[j]) begin
        w_any = 1'b1;
        w_idx = IDXW'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
      r_idx <= '0;
    end else begin
      if (r_state == IDLE && w_any) r_idx <= w_idx;
      if (r_state == DONE) begin
        if (int'(r_idx) == NUM_REQ - 1) r_ptr <= '0;
        else r_ptr <= r_idx + 1'b1;
      end
    end
  end
`else
  always_comb begin
    w_any = 1'b0;
    w_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_any && cmp_if.req[k]) begin
        w_any = 1'b1;
        w_idx = IDXW'(k);
      end
    end
  end
`endif

  assign w_win = NUM_REQ'(1) << w_idx;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_any) w_next = SETTLE;
      SETTLE:  w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant <= '0;
      r_done  <= '0;
      r_num1  <= '0;
      r_num2  <= '0;
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: if (w_any) begin
          r_grant <= w_win;
          r_num1  <= cmp_if.operand_a[int'(w_idx)*WIDTH +: WIDTH];
          r_num2  <= cmp_if.operand_b[int'(w_idx)*WIDTH +: WIDTH];
        end
        SETTLE: begin
          r_zero  <= cmp_if.cmp_zero_flag;
          // equal operands can never also report less-than
          r_carry <= cmp_if.cmp_carry_flag & ~cmp_if.cmp_zero_flag;
          r_done  <= r_grant;
        end
        DONE: begin
          r_done  <= '0;
          r_grant <= '0;
        end
        default: ;
      endcase
    end
  end

  assign cmp_if.grant        = r_grant;
  assign cmp_if.done         = r_done;
  assign cmp_if.result_zero  = r_zero;
  assign cmp_if.result_carry = r_carry;
  assign cmp_if.busy         = (r_state != IDLE);
  assign cmp_if.cmp_number1  = r_num1;
  assign cmp_if.cmp_number2  = r_num2;
endmodule
